// File: rtl/sdram_frame_unpacker.sv
// Read-side SDRAM pixel unpacker: two-entry prefetch of packed wr1/wr2 words,
// unpacked to 10-bit RGB, with per-frame pixel count and underflow tracking.
module sdram_frame_unpacker #(
    parameter int FRAME_PIXELS = 307200,
    parameter int CNT_W        = 19
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iFrameStart,
    input  logic             iRead,
    input  logic             iRd_empty,
    input  logic [15:0]      iRd1_data,
    input  logic [15:0]      iRd2_data,
    output logic             oRd_req,
    output logic [9:0]       oRed,
    output logic [9:0]       oGreen,
    output logic [9:0]       oBlue,
    output logic             oValid,
    output logic             oUnderflow,
    output logic [15:0]      oUnderflowCount,
    output logic [CNT_W-1:0] oPixelCount,
    output logic             oFrameDone
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;

    // Entry layout: {rd1[14:0], rd2[14:0]}; bit 15 of each word carries nothing.
    logic [29:0] buf_q [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  occ;
    logic        inflight;

    logic             active;
    logic             pop;
    logic             underrun;
    logic [1:0]       occ_next;
    logic [29:0]      head;
    logic [CNT_W-1:0] cnt_next;
    logic             frame_hit;

    logic unused_bits;
    assign unused_bits = ^{iRd1_data[15], iRd2_data[15]};

    // A frame-start pulse opens the new frame in the same cycle, so a read
    // arriving with it is served as that frame's first pixel.
    always_comb begin
        active   = iFrameStart || (state == RUN);
        pop      = iRead && active && (occ != 2'd0);
        underrun = iRead && active && (occ == 2'd0);
        occ_next = occ + {1'b0, inflight} - {1'b0, pop};
        oRd_req  = (state != IDLE) && !iRd_empty && (occ_next < 2'd2);
        head     = buf_q[rd_ptr];
    end

    always_comb begin
        cnt_next = oPixelCount;
        if (iFrameStart) begin
            cnt_next = iRead ? CNT_W'(1) : CNT_W'(0);
        end else if (state == RUN && iRead) begin
            cnt_next = oPixelCount + CNT_W'(1);
        end
        frame_hit = active && iRead
                    && (cnt_next == CNT_W'(FRAME_PIXELS));
    end

    always_ff @(posedge iClk) begin
        if (inflight) begin
            buf_q[wr_ptr] <= {iRd1_data[14:0], iRd2_data[14:0]};
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            occ      <= 2'd0;
            inflight <= 1'b0;
        end else begin
            inflight <= oRd_req;
            occ      <= occ_next;
            if (inflight) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state           <= IDLE;
            oRed            <= 10'd0;
            oGreen          <= 10'd0;
            oBlue           <= 10'd0;
            oValid          <= 1'b0;
            oUnderflow      <= 1'b0;
            oUnderflowCount <= 16'd0;
            oPixelCount     <= '0;
            oFrameDone      <= 1'b0;
        end else begin
            oValid <= iRead;
            if (pop) begin
                oRed   <= head[9:0];
                oGreen <= {head[29:25], head[14:10]};
                oBlue  <= head[24:15];
            end else begin
                oRed   <= 10'd0;
                oGreen <= 10'd0;
                oBlue  <= 10'd0;
            end

            oPixelCount <= cnt_next;

            if (iFrameStart) begin
                oUnderflow <= underrun;
            end else if (underrun) begin
                oUnderflow <= 1'b1;
            end

            if (underrun && oUnderflowCount != 16'hFFFF) begin
                oUnderflowCount <= oUnderflowCount + 16'd1;
            end

            if (iFrameStart) begin
                oFrameDone <= frame_hit;
            end else if (frame_hit) begin
                oFrameDone <= 1'b1;
            end

            unique case (1'b1)
                frame_hit:   state <= DONE;
                iFrameStart: state <= RUN;
                default:     state <= state;
            endcase
        end
    end

endmodule
